// File: rtl/scr1_pipe_mprf_ctrl.sv
// -----------------------------------------------------------------------------
// scr1_pipe_mprf_ctrl
//
// Sequencer/arbiter in front of the MPRF (x0..x31 register file).
//  - After reset it writes zero to x1..x(RF_SIZE-1), because the RAM-based
//    MPRF has no reset of its own.
//  - It then passes EXU read/write traffic straight through to the MPRF.
//  - A debug (HDU) requester shares the MPRF write port and the rs1 read port.
//    EXU always has priority. Debug accesses use cycles in which the EXU
//    neither writes nor reads.
//
// Ports
//  clk, rst                    clock, synchronous active-high reset
//  init_busy_o                 zero-fill in progress
//  exu_stall_o                 EXU must not access the MPRF this cycle
//  exu_rd_busy_i               EXU uses the rs1/rs2 read ports this cycle
//  exu_rs1/rs2_addr_i          EXU read addresses
//  exu_w_req_i, exu_rd_*_i     EXU write request, address and data
//  dbg_req_i ... dbg_wdata_i   debug request (held until ack), direction,
//                              address and write data
//  dbg_ack_o, dbg_rdata_o      one-cycle completion pulse, read data
//  mprf_*                      MPRF read/write port connections
// -----------------------------------------------------------------------------
module scr1_pipe_mprf_ctrl #(
  parameter int AWIDTH  = 5,
  parameter int XLEN    = 32,
  parameter int RF_SIZE = 32,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy_o,
  output logic              exu_stall_o,
  input  logic              exu_rd_busy_i,
  input  logic [AWIDTH-1:0] exu_rs1_addr_i,
  input  logic [AWIDTH-1:0] exu_rs2_addr_i,
  input  logic              exu_w_req_i,
  input  logic [AWIDTH-1:0] exu_rd_addr_i,
  input  logic [XLEN-1:0]   exu_rd_data_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [AWIDTH-1:0] dbg_addr_i,
  input  logic [XLEN-1:0]   dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [XLEN-1:0]   dbg_rdata_o,
  output logic [AWIDTH-1:0] mprf_rs1_addr_o,
  output logic [AWIDTH-1:0] mprf_rs2_addr_o,
  input  logic [XLEN-1:0]   mprf_rs1_data_i,
  output logic              mprf_w_req_o,
  output logic [AWIDTH-1:0] mprf_rd_addr_o,
  output logic [XLEN-1:0]   mprf_rd_data_o
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DRD  = 2'd2,
    ST_DACK = 2'd3
  } state_e;

  // One extra bit so that RF_SIZE == 2**AWIDTH is representable.
  localparam logic [AWIDTH:0]   RF_SIZE_W = (AWIDTH+1)'(RF_SIZE);
  localparam logic [AWIDTH-1:0] CNT_LAST  = AWIDTH'(RF_SIZE - 1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              dbg_ack_q;
  logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic              init_busy_q;
  logic              exu_stall_q;

  logic              dbg_grant_s;
  logic              dbg_addr_ok_s;
  logic [XLEN-1:0]   dbg_capture_s;

  // x0 and addresses beyond the implemented file are never written and read as zero.
  function automatic logic addr_ok(input logic [AWIDTH-1:0] addr);
    return (addr != {AWIDTH{1'b0}}) && ({1'b0, addr} < RF_SIZE_W);
  endfunction

  // The ack term is redundant while ack only occurs outside IDLE, but it keeps
  // an ack cycle from ever re-granting a request the HDU has not yet dropped.
  assign dbg_grant_s   = (state_q == ST_IDLE) & dbg_req_i & ~exu_w_req_i
                       & ~exu_rd_busy_i & ~dbg_ack_q;
  assign dbg_addr_ok_s = addr_ok(dbg_addr_i);
  assign dbg_capture_s = dbg_addr_ok_s ? mprf_rs1_data_i : {XLEN{1'b0}};

  // State register, init counter and registered status/debug outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= AWIDTH'(1'b1);
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= {XLEN{1'b0}};
      init_busy_q <= 1'b1;
      exu_stall_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dbg_ack_q   <= (state_d == ST_DACK);
      dbg_rdata_q <= dbg_rdata_d;
      init_busy_q <= (state_d == ST_INIT);
      exu_stall_q <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic, init counter and debug read-data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1'b1);
        end
      end
      ST_IDLE: begin
        if (dbg_grant_s) begin
          if (dbg_we_i) begin
            state_d = ST_DACK;
          end else if (RD_LAT == 0) begin
            state_d     = ST_DACK;
            dbg_rdata_d = dbg_capture_s;
          end else begin
            state_d = ST_DRD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRD: begin
        state_d     = ST_DACK;
        dbg_rdata_d = dbg_capture_s;
      end
      ST_DACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = AWIDTH'(1'b1);
      end
    endcase
  end

  // MPRF port steering: zero-fill, EXU pass-through or debug access.
  always_comb begin
    mprf_rs1_addr_o = exu_rs1_addr_i;
    mprf_rs2_addr_o = exu_rs2_addr_i;
    mprf_w_req_o    = 1'b0;
    mprf_rd_addr_o  = exu_rd_addr_i;
    mprf_rd_data_o  = exu_rd_data_i;
    case (state_q)
      ST_INIT: begin
        mprf_w_req_o   = 1'b1;
        mprf_rd_addr_o = cnt_q;
        mprf_rd_data_o = {XLEN{1'b0}};
      end
      ST_IDLE: begin
        mprf_w_req_o = exu_w_req_i;
        if (dbg_grant_s && dbg_we_i) begin
          mprf_w_req_o   = dbg_addr_ok_s;
          mprf_rd_addr_o = dbg_addr_i;
          mprf_rd_data_o = dbg_wdata_i;
        end else if (dbg_grant_s) begin
          mprf_rs1_addr_o = dbg_addr_i;
        end else begin
          mprf_rs1_addr_o = exu_rs1_addr_i;
        end
      end
      ST_DRD: begin
        mprf_rs1_addr_o = dbg_addr_i;
      end
      ST_DACK: begin
        mprf_w_req_o = 1'b0;
      end
      default: begin
        mprf_w_req_o = 1'b0;
      end
    endcase
  end

  assign init_busy_o = init_busy_q;
  assign exu_stall_o = exu_stall_q;
  assign dbg_ack_o   = dbg_ack_q;
  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_scr1_pipe_mprf_ctrl.sv
module tb_scr1_pipe_mprf_ctrl;
  localparam int AW  = 5;
  localparam int XL  = 32;
  localparam int RFS = 32;
  localparam int RDL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_busy_o, exu_stall_o;
  logic          exu_rd_busy_i = 1'b0;
  logic [AW-1:0] exu_rs1_addr_i = '0, exu_rs2_addr_i = '0, exu_rd_addr_i = '0;
  logic          exu_w_req_i = 1'b0;
  logic [XL-1:0] exu_rd_data_i = '0;
  logic          dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [XL-1:0] dbg_wdata_i = '0;
  logic          dbg_ack_o;
  logic [XL-1:0] dbg_rdata_o;
  logic [AW-1:0] mprf_rs1_addr_o, mprf_rs2_addr_o, mprf_rd_addr_o;
  logic [XL-1:0] mprf_rs1_data_i = '0;
  logic          mprf_w_req_o;
  logic [XL-1:0] mprf_rd_data_o;

  int errors = 0;
  int checks = 0;

  scr1_pipe_mprf_ctrl #(.AWIDTH(AW), .XLEN(XL), .RF_SIZE(RFS), .RD_LAT(RDL)) dut (
    .clk(clk), .rst(rst),
    .init_busy_o(init_busy_o), .exu_stall_o(exu_stall_o),
    .exu_rd_busy_i(exu_rd_busy_i), .exu_rs1_addr_i(exu_rs1_addr_i),
    .exu_rs2_addr_i(exu_rs2_addr_i), .exu_w_req_i(exu_w_req_i),
    .exu_rd_addr_i(exu_rd_addr_i), .exu_rd_data_i(exu_rd_data_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .mprf_rs1_addr_o(mprf_rs1_addr_o), .mprf_rs2_addr_o(mprf_rs2_addr_o),
    .mprf_rs1_data_i(mprf_rs1_data_i), .mprf_w_req_o(mprf_w_req_o),
    .mprf_rd_addr_o(mprf_rd_addr_o), .mprf_rd_data_o(mprf_rd_data_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Register-file RAM with one cycle of read latency; powers up with garbage.
  logic [XL-1:0] mem [0:RFS-1];
  initial for (int i = 0; i < RFS; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
  always @(posedge clk) begin
    if (mprf_w_req_o) mem[mprf_rd_addr_o] <= mprf_rd_data_o;
    mprf_rs1_data_i <= mem[mprf_rs1_addr_o];
  end

  // Behavioural model: architectural register contents plus remaining cycles
  // of the zero-fill phase and of the debug access in flight.
  bit            m_valid = 0;
  int            m_init_left = 0;
  int            m_op_left = 0;
  bit            m_op_rd = 0;
  logic [AW-1:0] m_op_addr = '0;
  logic [XL-1:0] m_exp_rdata = '0;
  logic [XL-1:0] shadow [0:RFS-1];
  bit            g, ok;

  always @(negedge clk) begin
    g  = dbg_req_i && !exu_w_req_i && !exu_rd_busy_i;
    ok = (dbg_addr_i != '0) && (int'(dbg_addr_i) < RFS);
    if (m_valid) begin
      if (m_init_left > 0) begin
        chk("init busy", 32'(init_busy_o), 32'd1);
        chk("init stall", 32'(exu_stall_o), 32'd1);
        chk("init ack", 32'(dbg_ack_o), 32'd0);
        chk("init wreq", 32'(mprf_w_req_o), 32'd1);
        chk("init waddr", 32'(mprf_rd_addr_o), 32'(RFS - m_init_left));
        chk("init wdata", mprf_rd_data_o, 32'd0);
      end else if (m_op_left > 0) begin
        chk("op busy", 32'(init_busy_o), 32'd0);
        chk("op stall", 32'(exu_stall_o), 32'd1);
        chk("op wreq", 32'(mprf_w_req_o), 32'd0);
        chk("op ack", 32'(dbg_ack_o), 32'(m_op_left == 1));
        if (m_op_rd && m_op_left > 1) chk("drd rs1", 32'(mprf_rs1_addr_o), 32'(m_op_addr));
        if (m_op_rd && m_op_left == 1) chk("dbg rdata", dbg_rdata_o, m_exp_rdata);
      end else begin
        chk("idle busy", 32'(init_busy_o), 32'd0);
        chk("idle stall", 32'(exu_stall_o), 32'd0);
        chk("idle ack", 32'(dbg_ack_o), 32'd0);
        chk("idle wreq", 32'(mprf_w_req_o), 32'(exu_w_req_i || (g && dbg_we_i && ok)));
        if (exu_w_req_i) begin
          chk("exu waddr", 32'(mprf_rd_addr_o), 32'(exu_rd_addr_i));
          chk("exu wdata", mprf_rd_data_o, exu_rd_data_i);
        end
        if (g && dbg_we_i && ok) begin
          chk("dbg waddr", 32'(mprf_rd_addr_o), 32'(dbg_addr_i));
          chk("dbg wdata", mprf_rd_data_o, dbg_wdata_i);
        end
        chk("idle rs1", 32'(mprf_rs1_addr_o), 32'((g && !dbg_we_i) ? dbg_addr_i : exu_rs1_addr_i));
        chk("idle rs2", 32'(mprf_rs2_addr_o), 32'(exu_rs2_addr_i));
      end
    end
    if (rst) begin
      m_valid     = 1;
      m_init_left = RFS - 1;
      m_op_left   = 0;
      for (int i = 0; i < RFS; i++) shadow[i] = '0;
    end else if (m_valid) begin
      if (m_init_left > 0) begin
        m_init_left--;
      end else if (m_op_left > 0) begin
        m_op_left--;
      end else begin
        if (exu_w_req_i && exu_rd_addr_i != '0) shadow[exu_rd_addr_i] = exu_rd_data_i;
        if (g) begin
          m_op_rd     = !dbg_we_i;
          m_op_addr   = dbg_addr_i;
          m_op_left   = dbg_we_i ? 1 : RDL + 1;
          m_exp_rdata = ok ? shadow[dbg_addr_i] : '0;
          if (dbg_we_i && ok) shadow[dbg_addr_i] = dbg_wdata_i;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name, input int exp_n, input bit chk_rd, input logic [31:0] exp_rd);
    int n = 0;
    bit got = 0;
    while (!got && n < 200) begin
      step();
      n++;
      if (dbg_ack_o) got = 1;
    end
    chk({name, " ack latency"}, 32'(n), 32'(exp_n));
    if (got && chk_rd) chk({name, " rdata"}, dbg_rdata_o, exp_rd);
    dbg_req_i = 1'b0;
  endtask

  task automatic dbg_op(input string name, input bit we, input logic [AW-1:0] addr,
                        input logic [XL-1:0] wd, input int exp_n, input logic [31:0] exp_rd);
    step();
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
    wait_ack(name, exp_n, !we, exp_rd);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    step();
    chk("reset init_busy", 32'(init_busy_o), 32'd1);
    chk("reset stall", 32'(exu_stall_o), 32'd1);
    chk("reset ack", 32'(dbg_ack_o), 32'd0);
    chk("reset rdata", dbg_rdata_o, 32'd0);
    step();
    rst = 1'b0;

    // 1. Zero-fill length: init_busy falls on cycle 32 after release.
    n = 1;
    while (init_busy_o && n < 200) begin step(); n++; end
    chk("init length", 32'(n), 32'd32);

    // 2. EXU pass-through
    step();
    exu_w_req_i = 1'b1; exu_rd_addr_i = 5'd5; exu_rd_data_i = 32'hDEADBEEF;
    exu_rd_busy_i = 1'b1; exu_rs1_addr_i = 5'd5; exu_rs2_addr_i = 5'd3;
    #1;
    chk("t2 wreq", 32'(mprf_w_req_o), 32'd1);
    chk("t2 waddr", 32'(mprf_rd_addr_o), 32'd5);
    chk("t2 wdata", mprf_rd_data_o, 32'hDEADBEEF);
    chk("t2 rs1", 32'(mprf_rs1_addr_o), 32'd5);
    chk("t2 rs2", 32'(mprf_rs2_addr_o), 32'd3);
    chk("t2 ack", 32'(dbg_ack_o), 32'd0);
    step();
    exu_w_req_i = 1'b0; exu_rd_busy_i = 1'b0;

    // 3. Debug write then read of x7
    dbg_op("t3 wr x7", 1'b1, 5'd7, 32'h12345678, 1, 32'd0);
    dbg_op("t3 rd x7", 1'b0, 5'd7, 32'd0, 2, 32'h12345678);

    // 4. Debug read held behind three EXU writes
    step();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
    for (int i = 0; i < 3; i++) begin
      exu_w_req_i = 1'b1; exu_rd_addr_i = 5'(10 + i); exu_rd_data_i = 32'h1010_0000 + 32'(i);
      #1;
      chk("t4 exu waddr", 32'(mprf_rd_addr_o), 32'(10 + i));
      chk("t4 no ack", 32'(dbg_ack_o), 32'd0);
      step();
    end
    exu_w_req_i = 1'b0;
    wait_ack("t4 rd x5", 2, 1'b1, 32'hDEADBEEF);
    dbg_op("t4 rd x11", 1'b0, 5'd11, 32'd0, 2, 32'h1010_0001);

    // 5. x0 handling
    step();
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_wdata_i = 32'hFFFFFFFF;
    #1;
    chk("t5 x0 wreq", 32'(mprf_w_req_o), 32'd0);
    wait_ack("t5 wr x0", 1, 1'b0, 32'd0);
    dbg_op("t5 rd x0", 1'b0, 5'd0, 32'd0, 2, 32'd0);

    // 6. Reset during a debug read
    dbg_op("t6 wr x9", 1'b1, 5'd9, 32'hCAFE0009, 1, 32'd0);
    step();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd9;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 no ack", 32'(dbg_ack_o), 32'd0);
    chk("t6 init_busy", 32'(init_busy_o), 32'd1);
    wait_ack("t6 rd x9", 33, 1'b1, 32'd0);

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
